pipe_ctrl: RTL
==============

# pipe_ctrl

Central sequencing controller for the linear valid/ready pipeline (stage_1 … stage_N). It computes every stage's clock enable from per-stage stall requests and stage valid bits, and gates the source handshake into stage 0. It also owns pipeline-wide flush, drain and halt sequencing, and keeps a saturating stall-cycle performance counter. It sits beside the pipeline; stages consume `o_ce[k]` as their `is_ce` and `o_flush` as their `i_flush`.

## Interface
- `NUM_STAGES`, default 3: number of pipeline stages controlled (≥2).
- `FLUSH_CYCLES`, default 1: cycles `o_flush` is held per flush (≥1).
- `CNT_W`, default 16: stall counter width.

- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_src_valid` in 1: upstream source has data.
- `o_src_ready` out 1: stage 0 accepts source data this cycle.
- `o_s0_valid` out 1: `i_src_valid & o_src_ready`; drives stage 0 `i_valid`.
- `i_stage_valid` in NUM_STAGES: registered `o_valid` of each stage (bit 0 = first stage).
- `i_stall_req` in NUM_STAGES: per-stage internal stall request.
- `i_dn_ready` in 1: sink after the last stage accepts data.
- `o_ce` out NUM_STAGES: per-stage clock enable.
- `i_flush_req` in 1: request a pipeline flush (level, sampled per cycle).
- `i_drain_req` in 1: stop accepting source data, empty the pipe, then halt.
- `i_resume` in 1: leave HALT.
- `o_flush` out 1: flush to all stages (registered).
- `o_idle` out 1: high in HALT.
- `o_state` out 2: RUN=0, FLUSH=1, DRAIN=2, HALT=3.
- `i_clr_cnt` in 1: synchronous clear of the stall counter.
- `o_stall_cnt` out CNT_W: saturating stall-cycle count.

## Operation
- **Enable chain (combinational, RUN/DRAIN only):**
  - Last stage: `ce[N-1] = ~stall_req[N-1] & (i_dn_ready | ~stage_valid[N-1])`.
  - Other stages: `ce[k] = ~stall_req[k] & (ce[k+1] | ~stage_valid[k])`.
  - A stage holding valid data is enabled only if its successor advances. Empty stages may load regardless of the successor.
- **FLUSH/HALT:** `o_ce` is all zeros.
- **o_src_ready:** equals `ce[0]` in RUN; 0 in every other state.
- **FSM:** state is registered. Priority is flush > drain > resume.
  - RUN: `i_flush_req` → FLUSH. Else `i_drain_req` → DRAIN.
  - DRAIN: `i_flush_req` → FLUSH with `hold` set. Else, when `i_stage_valid == 0` → HALT.
  - HALT: `i_flush_req` → FLUSH with `hold` set. Else `i_resume` → RUN.
  - FLUSH: lasts exactly `FLUSH_CYCLES` cycles, counted by an internal down-counter. Exit goes to HALT if `hold`, else RUN; `hold` clears on exit. `i_flush_req` asserted during FLUSH is ignored and does not extend it.
- **o_flush:** high exactly while the state is FLUSH.
- **Stall counter:**
  - Increments in a cycle where state is RUN or DRAIN and some stage k has `stage_valid[k] & ~ce[k]`.
  - Saturates at all-ones and does not wrap.
  - `i_clr_cnt` has priority over increment and loads 0.

## Timing
- **Reset values:** state RUN; `o_flush`=0; `o_idle`=0; `o_stall_cnt`=0; `hold`=0; flush counter=0. `o_ce` and `o_src_ready` then follow the RUN equations combinationally.
- **Latency:**
  - Request inputs are sampled at a clock edge; the state change is visible the next cycle.
  - `i_flush_req` high at edge t → `o_flush` high in cycles t+1 … t+FLUSH_CYCLES.
  - The new state (RUN/HALT) takes effect at cycle t+FLUSH_CYCLES+1.
- **Enable path:** `o_ce`, `o_src_ready` and `o_s0_valid` are combinational from current inputs and registered state, with no cycle delay. The chain ripples from the last stage to stage 0.
- **Drain → HALT:** HALT is entered at the edge where `i_stage_valid` is sampled all zero, so `o_idle` rises the following cycle.
- **Simultaneous events:**
  - `i_flush_req` and `i_drain_req` together in RUN → FLUSH with `hold`=0; drain is re-evaluated after the flush.
  - `i_resume` and `i_flush_req` together in HALT → FLUSH with `hold`=1.
- **Reset mid-operation:** an asynchronous return to RUN from any state. Pending flush or drain is discarded, and the counter is cleared.

## Test plan
- **Free flow:** N=3, no stalls, `i_dn_ready`=1, source valid every cycle → `o_ce`=3'b111, `o_src_ready`=1, `o_stall_cnt` stays 0.
- **Backpressure ripple:** all stages valid, `i_dn_ready`=0 → `o_ce`=3'b000 and the counter increments each cycle. Then set `stage_valid`=3'b011 with `i_stall_req[1]`=1 → `o_ce`=3'b100, and stage 0 is disabled because it is valid and its successor is stalled.
- **Flush:** FLUSH_CYCLES=2, pulse `i_flush_req` at edge 10 → `o_flush`=1 in cycles 11–12, `o_ce`=0 in those cycles, state RUN at cycle 13.
- **Drain/halt/resume:**
  - `i_drain_req` with 3 valid stages and `i_dn_ready`=1 → `o_src_ready`=0 immediately after entering DRAIN.
  - Valids empty after 3 cycles → `o_idle`=1 the next cycle.
  - `i_resume` → RUN and `o_src_ready`=1.
- **Flush during drain:** flush in DRAIN → FLUSH, then HALT (not RUN).
- **Counter saturation and reset:** CNT_W=4 with a permanent stall → `o_stall_cnt` holds at 15. `i_clr_cnt` → 0. Async `i_rst_n` low mid-FLUSH → `o_flush` drops to 0 immediately and state reads RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage clock-enable chain, source gating, flush/drain/halt sequencing
// and a saturating stall-cycle counter for a linear valid/ready pipeline.
module pipe_ctrl #(
  parameter int NUM_STAGES   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_src_valid,
  output logic                  o_src_ready,
  output logic                  o_s0_valid,
  input  logic [NUM_STAGES-1:0] i_stage_valid,
  input  logic [NUM_STAGES-1:0] i_stall_req,
  input  logic                  i_dn_ready,
  output logic [NUM_STAGES-1:0] o_ce,
  input  logic                  i_flush_req,
  input  logic                  i_drain_req,
  input  logic                  i_resume,
  output logic                  o_flush,
  output logic                  o_idle,
  output logic [1:0]            o_state,
  input  logic                  i_clr_cnt,
  output logic [CNT_W-1:0]      o_stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic                hold_q, hold_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                flush_q, idle_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] chain;
  logic                moving, stalled;

  // A valid stage may only advance when its successor advances; empty stages always load.
  always_comb begin
    chain = '0;
    chain[NUM_STAGES-1] = ~i_stall_req[NUM_STAGES-1] & (i_dn_ready | ~i_stage_valid[NUM_STAGES-1]);
    for (int k = NUM_STAGES - 2; k >= 0; k--)
      chain[k] = ~i_stall_req[k] & (chain[k+1] | ~i_stage_valid[k]);
  end

  assign moving      = (state_q == RUN) | (state_q == DRAIN);
  assign o_ce        = moving ? chain : '0;
  assign o_src_ready = (state_q == RUN) & chain[0];
  assign o_s0_valid  = i_src_valid & o_src_ready;
  assign stalled     = moving & |(i_stage_valid & ~chain);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        state_d = i_flush_req ? FLUSH : i_drain_req ? DRAIN : RUN;
        fcnt_d  = i_flush_req ? FLOAD : fcnt_q;
        hold_d  = 1'b0;
      end
      DRAIN, HALT: begin
        state_d = i_flush_req ? FLUSH
                : (state_q == DRAIN) ? ((i_stage_valid == '0) ? HALT : DRAIN)
                : (i_resume ? RUN : HALT);
        fcnt_d  = i_flush_req ? FLOAD : fcnt_q;
        hold_d  = i_flush_req | hold_q;
      end
      default: begin
        state_d = (fcnt_q != '0) ? FLUSH : hold_q ? HALT : RUN;
        fcnt_d  = (fcnt_q != '0) ? fcnt_q - 1'b1 : fcnt_q;
        hold_d  = (fcnt_q != '0) & hold_q;
      end
    endcase
  end

  assign cnt_d = i_clr_cnt ? '0 : (stalled & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      hold_q  <= 1'b0;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
      idle_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fcnt_q  <= fcnt_d;
      flush_q <= state_d == FLUSH;
      idle_q  <= state_d == HALT;
      cnt_q   <= cnt_d;
    end
  end

  assign o_flush     = flush_q;
  assign o_idle      = idle_q;
  assign o_state     = state_q;
  assign o_stall_cnt = cnt_q;
endmodule
